// File: rtl/reorder_buffer.sv
// reorder_buffer
//
// Circular reorder buffer. Hands out ROB tags (ROBEN) at decode, captures
// results broadcast on the CDB, and retires entries strictly in program order
// through the register-file commit write port (WP1_*).
//
// Entry index i carries tag i+1; tag 0 is reserved to mean "no pending
// producer", so it never addresses an entry.
//
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   flush                   synchronous clear of all entries
//   alloc_valid/writes/DRindex  allocation request from decode
//   alloc_ready, alloc_ROBEN    combinational grant and tag of the tail entry
//   cdb_valid/ROBEN/Data        result broadcast
//   rd_ROBEN1/2 -> rd_ready1/2, rd_data1/2   operand lookups (with CDB bypass)
//   WP1_Wen/ROBEN/DRindex/Data  registered commit write port
//   empty, full                 occupancy flags
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc_valid,
   input  logic             alloc_writes,
   input  logic [4:0]       alloc_DRindex,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_ROBEN,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_ROBEN,
   input  logic [31:0]      cdb_Data,
   input  logic [TAG_W-1:0] rd_ROBEN1,
   input  logic [TAG_W-1:0] rd_ROBEN2,
   output logic             rd_ready1,
   output logic             rd_ready2,
   output logic [31:0]      rd_data1,
   output logic [31:0]      rd_data2,
   output logic             WP1_Wen,
   output logic [TAG_W-1:0] WP1_ROBEN,
   output logic [4:0]       WP1_DRindex,
   output logic [31:0]      WP1_Data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [TAG_W-1:0] MAX_TAG  = TAG_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Control state (reset) and payload (not reset).
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] done_q;
   logic [DEPTH-1:0] writes_q;
   logic [4:0]       dr_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];

   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
      return (t != '0) && (t <= MAX_TAG);
   endfunction

   function automatic logic [PTR_W-1:0] tag_to_idx(input logic [TAG_W-1:0] t);
      return PTR_W'(t - TAG_W'(1));
   endfunction

   logic             alloc_fire;
   logic             commit_fire;
   logic             cdb_fire;
   logic [PTR_W-1:0] cdb_idx;

   // Grant depends on the current count only, so a full buffer refuses an
   // allocation even when a commit frees an entry on the same edge.
   assign alloc_ready = (count_q < FULL_CNT) && !flush;
   assign alloc_ROBEN = TAG_W'(tail_q) + TAG_W'(1);
   assign alloc_fire  = alloc_valid && alloc_ready;

   // Commit looks only at registered done bits: a CDB write to the head entry
   // retires on the following edge, never in the same cycle.
   assign commit_fire = valid_q[head_q] && done_q[head_q];

   // The entry being allocated is not yet valid, so a CDB aimed at it drops.
   assign cdb_idx  = tag_to_idx(cdb_ROBEN);
   assign cdb_fire = cdb_valid && tag_in_range(cdb_ROBEN) &&
                     valid_q[cdb_idx] && !done_q[cdb_idx];

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

   // Control path: pointers, count, valid/done bits and commit port.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         done_q      <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         WP1_Wen     <= 1'b0;
         WP1_ROBEN   <= '0;
         WP1_DRindex <= '0;
         WP1_Data    <= '0;
      end else if (flush) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         WP1_Wen <= 1'b0;
      end else begin
         if (alloc_fire) begin
            valid_q[tail_q] <= 1'b1;
            done_q[tail_q]  <= 1'b0;
            tail_q          <= ptr_inc(tail_q);
         end

         if (cdb_fire) begin
            done_q[cdb_idx] <= 1'b1;
         end

         // head and tail coincide only when empty (no commit) or full (no
         // alloc), so the commit and alloc writes never hit the same entry.
         WP1_Wen <= commit_fire && writes_q[head_q];
         if (commit_fire) begin
            valid_q[head_q] <= 1'b0;
            WP1_ROBEN       <= TAG_W'(head_q) + TAG_W'(1);
            WP1_DRindex     <= dr_q[head_q];
            WP1_Data        <= data_q[head_q];
            head_q          <= ptr_inc(head_q);
         end

         case ({alloc_fire, commit_fire})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload path.
   // NOTE: payload arrays are deliberately not reset; valid/done gate every
   // use, so stale contents are never observed and the arrays stay plain RAM.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         writes_q[tail_q] <= alloc_writes;
         dr_q[tail_q]     <= alloc_DRindex;
      end
      if (cdb_fire) begin
         data_q[cdb_idx] <= cdb_Data;
      end
   end

   // Operand lookup, two identical ports.
   logic [TAG_W-1:0] rd_tag   [2];
   logic             rd_ready [2];
   logic [31:0]      rd_data  [2];

   assign rd_tag[0] = rd_ROBEN1;
   assign rd_tag[1] = rd_ROBEN2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         // NOTE: defaults first so every path assigns both outputs and no
         // latch is inferred.
         rd_ready[p] = 1'b0;
         rd_data[p]  = '0;
         if (tag_in_range(rd_tag[p])) begin
            if (cdb_valid && (cdb_ROBEN == rd_tag[p])) begin
               rd_ready[p] = 1'b1;
               rd_data[p]  = cdb_Data;
            end else if (valid_q[tag_to_idx(rd_tag[p])] &&
                         done_q[tag_to_idx(rd_tag[p])]) begin
               rd_ready[p] = 1'b1;
               rd_data[p]  = data_q[tag_to_idx(rd_tag[p])];
            end
         end
      end
   end

   assign rd_ready1 = rd_ready[0];
   assign rd_ready2 = rd_ready[1];
   assign rd_data1  = rd_data[0];
   assign rd_data2  = rd_data[1];

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer for the SSOOO core.
- Allocates ROB tags (ROBEN) to instructions at decode and captures results broadcast on the CDB.
- Retires entries strictly in program order.
- Drives the register file commit write port: WP1_Wen, WP1_ROBEN, WP1_DRindex, WP1_Data.
- The register file clears a register's pending tag only when WP1_ROBEN matches the tag it holds.

Parameters:
DEPTH, 16, number of entries; legal range 2..31; tags are 1..DEPTH.
TAG_W, 5, ROBEN width; tag 0 is reserved and means "value in register file, no pending producer".

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
flush  in  1  synchronous clear of all entries (mispredict/exception).
alloc_valid  in  1  decode requests one entry this cycle.
alloc_writes  in  1  instruction writes a destination register.
alloc_DRindex  in  5  destination register index.
alloc_ready  out  1  combinational; 1 when count < DEPTH and flush = 0.
alloc_ROBEN  out  TAG_W  combinational tag of the tail entry (tail+1); valid when alloc_ready = 1.
cdb_valid  in  1  result broadcast valid.
cdb_ROBEN  in  TAG_W  tag of broadcast result.
cdb_Data  in  32  broadcast result value.
rd_ROBEN1, rd_ROBEN2  in  TAG_W  operand lookup tags.
rd_ready1, rd_ready2  out  1  combinational; result available for that tag.
rd_data1, rd_data2  out  32  combinational result value; 0 when not ready.
WP1_Wen  out  1  registered commit write enable to the register file.
WP1_ROBEN  out  TAG_W  registered tag of the committing entry.
WP1_DRindex  out  5  registered destination index.
WP1_Data  out  32  registered commit data.
empty  out  1  count == 0.
full  out  1  count == DEPTH.

Behaviour:
Per-entry state and pointers
- Each entry holds: valid, done, writes, DRindex[4:0], data[31:0].
- head and tail run 0..DEPTH-1 and wrap DEPTH-1 -> 0; count runs 0..DEPTH.
- Entry index i carries tag i+1.

Reset (rst = 1)
- head = tail = count = 0; all valid and done bits cleared.
- WP1_Wen = 0, WP1_ROBEN = 0, WP1_DRindex = 0, WP1_Data = 0.
- Outputs after reset: alloc_ready = 1, alloc_ROBEN = 1, empty = 1, full = 0.
- rst has top priority over every other input, including mid-stream activity.

Flush (flush = 1, rst = 0)
- Same state clear as reset.
- Next cycle WP1_Wen = 0; WP1_ROBEN, WP1_DRindex and WP1_Data may hold stale values.
- Alloc, CDB and commit are all ignored in the flush cycle.

Allocate (alloc_valid && alloc_ready)
- Entry[tail]: valid = 1, done = 0, writes and DRindex captured.
- tail advances by one.
- alloc_ready is computed from the current count, so a full ROB refuses allocation even if a commit frees an entry in the same cycle.

Complete (cdb_valid)
- If entry[cdb_ROBEN-1] is valid and not done: data = cdb_Data, done = 1.
- Ignored for tag 0, tag > DEPTH, invalid entries, or entries already done.

Commit
- Condition: entry[head] valid && done at the clock edge.
- Next cycle: WP1_Wen = writes, WP1_ROBEN = head+1, WP1_DRindex = DRindex, WP1_Data = data.
- Entry invalidated; head advances.
- At most one commit per cycle; with no commit, WP1_Wen = 0 for that cycle.
- A CDB write to the head entry in cycle N commits in cycle N+1, so WP1 appears at N+2. There is no same-cycle CDB-to-commit path.
- Entries with writes = 0 retire with WP1_Wen = 0.

Simultaneous events
- Alloc and commit in one cycle: count unchanged.
- Alloc and CDB in one cycle: CDB cannot target the entry being allocated (it is not yet valid), so that CDB is ignored.

Lookup (per port)
- If rd_ROBEN == 0 or rd_ROBEN > DEPTH: ready = 0, data = 0.
- Else if cdb_valid && cdb_ROBEN == rd_ROBEN: ready = 1, data = cdb_Data (bypass).
- Else: ready = valid && done of that entry; data = the entry's data when ready, otherwise 0.

Test Plan:
- rst one cycle -> WP1_Wen = 0, empty = 1, alloc_ready = 1, alloc_ROBEN = 1; rd_ROBEN1 = 0 -> rd_ready1 = 0.
- Allocate 3 (DR 1, 2, 3; writes = 1); CDB tag 3 = 30, then tag 1 = 10, then tag 2 = 20 -> commits in order:
  - (ROBEN 1, DR 1, 10), then (2, 2, 20), then (3, 3, 30), on consecutive cycles after tag 2 completes;
  - no WP1_Wen before tag 1 completes.
- Allocate 16 without completing -> full = 1, alloc_ready = 0; a 17th alloc_valid is ignored. Complete and commit tag 1, then allocate -> alloc_ROBEN = 1 (wrap), count = 16.
- Entry tag 2 pending; cdb_valid with tag 2 = 0xDEAD and rd_ROBEN1 = 2 in the same cycle -> rd_ready1 = 1, rd_data1 = 0xDEAD combinationally.
- Allocate 4, complete 2, assert flush -> next cycle empty = 1, WP1_Wen = 0, alloc_ROBEN = 1; a late CDB with tag 2 is ignored.
- Allocate with writes = 0 and complete it -> it retires with WP1_Wen = 0 and head advances; a following writes = 1 entry commits normally with WP1_Wen = 1.
